// File: rtl/pix_pkg.sv
// Shared definitions for the SPI-to-NeoPixel command path: command opcodes, the command FSM
// state type and the 24-bit GRB pixel word.
package pix_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_SHOW  = 8'h02;
  localparam logic [7:0] CMD_COUNT = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StPix,
    StCount,
    StDrain
  } ctrl_state_e;

  // {G, R, B}
  typedef logic [23:0] pix_word_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level.
// Ports:
//   clk    - destination clock
//   reset  - synchronous, active-high; loads RESET_VAL into every stage
//   d_i    - asynchronous input level
//   q_o    - synchronized level, STAGES clocks behind d_i
module sync_ff #(
  parameter int unsigned STAGES    = 4,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_pix_cmd_ctrl.sv
// Command sequencer between the SPI receive slave and the NeoPixel serializer. Parses the bytes
// of each SPI transaction, assembles GRB triplets into pixel-buffer writes, sets the active pixel
// count and issues show requests through a start/busy handshake.
// Ports:
//   clk, reset   - system clock; synchronous active-high reset
//   ssel_n       - raw SPI chip select (asynchronous, active low)
//   rx_data      - received byte, valid with rx_ready
//   rx_ready     - one-cycle pulse per received byte
//   pix_we       - pixel buffer write strobe (one cycle)
//   pix_addr     - pixel buffer write address
//   pix_wdata    - {G,R,B} write data
//   pix_count    - active pixel count for the serializer
//   show_start   - one-cycle pulse starting a frame
//   show_busy    - serializer is transmitting a frame
//   ovf_flag     - sticky: write past the last pixel, bad address or unknown command
module spi_pix_cmd_ctrl
  import pix_pkg::*;
#(
  parameter  int unsigned NUM_PIX = 64,
  localparam int unsigned ADDR_W  = $clog2(NUM_PIX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ssel_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [23:0]       pix_wdata,
  output logic [ADDR_W:0]   pix_count,
  output logic              show_start,
  input  logic              show_busy,
  output logic              ovf_flag
);

  localparam logic [ADDR_W:0] NumPixW = (ADDR_W + 1)'(NUM_PIX);

  // Four stages so the last byte's rx_ready lands before the end of the transaction is seen.
  logic ssel_sync;

  sync_ff #(
    .STAGES   (4),
    .RESET_VAL(1'b1)
  ) u_ssel_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (ssel_n),
    .q_o  (ssel_sync)
  );

  logic txn_active, txn_q, txn_rise, txn_fall;
  assign txn_active = ~ssel_sync;
  assign txn_rise   = txn_active & ~txn_q;
  assign txn_fall   = ~txn_active & txn_q;

  ctrl_state_e     state_q, state_d;
  // One bit wider than the buffer address so "one past the last pixel" is representable.
  logic [ADDR_W:0] addr_q, addr_d;
  logic [1:0]      phase_q, phase_d;
  logic [7:0]      g_q, g_d, r_q, r_d;
  logic            pix_we_q, pix_we_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  pix_word_t       pix_wdata_q, pix_wdata_d;
  logic [ADDR_W:0] pix_count_q, pix_count_d;
  logic            ovf_q, ovf_d;
  logic            show_pend_q, show_pend_d;
  logic            show_start_q, show_start_d;
  logic            guard_q;
  logic            show_req;
  logic            show_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      txn_q        <= 1'b0;
      addr_q       <= '0;
      phase_q      <= 2'd0;
      g_q          <= 8'd0;
      r_q          <= 8'd0;
      pix_we_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_wdata_q  <= '0;
      pix_count_q  <= NumPixW;
      ovf_q        <= 1'b0;
      show_pend_q  <= 1'b0;
      show_start_q <= 1'b0;
      guard_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      txn_q        <= txn_active;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      g_q          <= g_d;
      r_q          <= r_d;
      pix_we_q     <= pix_we_d;
      pix_addr_q   <= pix_addr_d;
      pix_wdata_q  <= pix_wdata_d;
      pix_count_q  <= pix_count_d;
      ovf_q        <= ovf_d;
      show_pend_q  <= show_pend_d;
      show_start_q <= show_start_d;
      guard_q      <= show_start_q;
    end
  end

  // Command parser and triplet assembler.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    g_d         = g_q;
    r_d         = r_q;
    pix_we_d    = 1'b0;
    pix_addr_d  = pix_addr_q;
    pix_wdata_d = pix_wdata_q;
    pix_count_d = pix_count_q;
    ovf_d       = ovf_q;
    show_req    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (txn_rise) state_d = StCmd;
      end
      StCmd: begin
        if (rx_ready) begin
          unique case (rx_data)
            CMD_WRITE: state_d = StAddr;
            CMD_SHOW: begin
              show_req = 1'b1;
              state_d  = StDrain;
            end
            CMD_COUNT: state_d = StCount;
            default: begin
              ovf_d   = 1'b1;
              state_d = StDrain;
            end
          endcase
        end
      end
      StAddr: begin
        if (rx_ready) begin
          if ({24'd0, rx_data} >= NUM_PIX) begin
            ovf_d   = 1'b1;
            state_d = StDrain;
          end else begin
            addr_d  = (ADDR_W + 1)'(rx_data);
            phase_d = 2'd0;
            state_d = StPix;
          end
        end
      end
      StPix: begin
        if (rx_ready) begin
          if (addr_q == NumPixW) begin
            // Last pixel already written: no wrap.
            ovf_d   = 1'b1;
            state_d = StDrain;
          end else begin
            unique case (phase_q)
              2'd0: begin
                g_d     = rx_data;
                phase_d = 2'd1;
              end
              2'd1: begin
                r_d     = rx_data;
                phase_d = 2'd2;
              end
              default: begin
                pix_we_d    = 1'b1;
                pix_addr_d  = addr_q[ADDR_W-1:0];
                pix_wdata_d = {g_q, r_q, rx_data};
                addr_d      = addr_q + 1'b1;
                phase_d     = 2'd0;
              end
            endcase
          end
        end
      end
      StCount: begin
        if (rx_ready) begin
          if ({24'd0, rx_data} >= NUM_PIX) begin
            pix_count_d = NumPixW;
          end else begin
            pix_count_d = (ADDR_W + 1)'(rx_data);
          end
          state_d = StDrain;
        end
      end
      default: ;  // StDrain ignores bytes
    endcase

    // A byte coinciding with the end of the transaction is processed above first.
    if (txn_fall) begin
      state_d = StIdle;
      phase_d = 2'd0;
    end
  end

  // Busy is not trusted while start is out or the cycle after it, as the serializer may not
  // have raised it yet.
  assign show_fire = show_pend_q & ~show_busy & ~show_start_q & ~guard_q;

  always_comb begin
    show_start_d = show_fire;
    show_pend_d  = (show_pend_q & ~show_fire) | show_req;
  end

  assign pix_we     = pix_we_q;
  assign pix_addr   = pix_addr_q;
  assign pix_wdata  = pix_wdata_q;
  assign pix_count  = pix_count_q;
  assign show_start = show_start_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_spi_pix_cmd_ctrl.sv
module tb_spi_pix_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ssel_n;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        pix_we;
  logic [5:0]  pix_addr;
  logic [23:0] pix_wdata;
  logic [6:0]  pix_count;
  logic        show_start;
  logic        show_busy;
  logic        ovf_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_pix_cmd_ctrl #(.NUM_PIX(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .ssel_n    (ssel_n),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .pix_we    (pix_we),
    .pix_addr  (pix_addr),
    .pix_wdata (pix_wdata),
    .pix_count (pix_count),
    .show_start(show_start),
    .show_busy (show_busy),
    .ovf_flag  (ovf_flag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write and start monitor.
  logic [5:0]  wr_a[$];
  logic [23:0] wr_d[$];
  int          start_cnt = 0;
  logic        rdy_at_edge = 1'b0;
  logic        we_prev = 1'b0;
  logic        start_prev = 1'b0;

  always @(posedge clk) rdy_at_edge <= rx_ready;

  always @(negedge clk) begin
    if (!reset) begin
      if (pix_we) begin
        chk("we_latency", {31'd0, rdy_at_edge}, 32'd1);
        chk("we_single", {31'd0, we_prev}, 32'd0);
        wr_a.push_back(pix_addr);
        wr_d.push_back(pix_wdata);
      end
      if (show_start) begin
        chk("start_single", {31'd0, start_prev}, 32'd0);
        start_cnt++;
      end
    end
    we_prev    = pix_we;
    start_prev = show_start;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic open_txn();
    ssel_n = 1'b0;
    step(6);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(3);
  endtask

  task automatic close_txn();
    step(2);
    ssel_n = 1'b1;
    step(8);
  endtask

  typedef struct {
    logic        rst;
    int          n;
    logic [71:0] bytes;  // first byte in the top bits
    int          nwr;
    logic [5:0]  wa[2];
    logic [23:0] wd[2];
    logic [6:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t tv[$];

  task automatic add_vec(input logic rst, input int n, input logic [71:0] bytes, input int nwr,
                         input logic [5:0] a0, input logic [23:0] d0, input logic [5:0] a1,
                         input logic [23:0] d1, input logic [6:0] cnt, input logic ovf);
    vec_t v;
    v.rst = rst; v.n = n; v.bytes = bytes; v.nwr = nwr;
    v.wa[0] = a0; v.wd[0] = d0; v.wa[1] = a1; v.wd[1] = d1;
    v.cnt = cnt; v.ovf = ovf;
    tv.push_back(v);
  endtask

  initial begin
    reset     = 1'b1;
    ssel_n    = 1'b1;
    rx_data   = 8'd0;
    rx_ready  = 1'b0;
    show_busy = 1'b0;
    step(3);
    chk("rst_we", {31'd0, pix_we}, 32'd0);
    chk("rst_addr", {26'd0, pix_addr}, 32'd0);
    chk("rst_wdata", {8'd0, pix_wdata}, 32'd0);
    chk("rst_count", {25'd0, pix_count}, 32'd64);
    chk("rst_start", {31'd0, show_start}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_flag}, 32'd0);
    reset = 1'b0;
    step(2);

    //      rst n  bytes                    nwr a0     d0          a1     d1          cnt ovf
    add_vec(0, 8, 72'h010510203040506000, 2, 6'h05, 24'h102030, 6'h06, 24'h405060, 64, 0);
    add_vec(0, 4, 72'h0100AABB0000000000, 0, 6'h00, 24'h0,      6'h00, 24'h0,      64, 0);
    add_vec(0, 2, 72'h030A00000000000000, 0, 6'h00, 24'h0,      6'h00, 24'h0,      10, 0);
    add_vec(0, 2, 72'h03FF00000000000000, 0, 6'h00, 24'h0,      6'h00, 24'h0,      64, 0);
    add_vec(0, 2, 72'h030000000000000000, 0, 6'h00, 24'h0,      6'h00, 24'h0,       0, 0);
    add_vec(0, 2, 72'h034000000000000000, 0, 6'h00, 24'h0,      6'h00, 24'h0,      64, 0);
    add_vec(0, 2, 72'h033F00000000000000, 0, 6'h00, 24'h0,      6'h00, 24'h0,      63, 0);
    add_vec(0, 2, 72'h034100000000000000, 0, 6'h00, 24'h0,      6'h00, 24'h0,      64, 0);
    add_vec(0, 9, 72'h013EAABBCC11223344, 2, 6'h3E, 24'hAABBCC, 6'h3F, 24'h112233, 64, 1);
    add_vec(1, 1, 72'h070000000000000000, 0, 6'h00, 24'h0,      6'h00, 24'h0,      64, 1);
    add_vec(0, 5, 72'h010101020300000000, 1, 6'h01, 24'h010203, 6'h00, 24'h0,      64, 1);
    add_vec(1, 5, 72'h0140AABBCC00000000, 0, 6'h00, 24'h0,      6'h00, 24'h0,      64, 1);
    add_vec(1, 5, 72'h013FAABBCC00000000, 1, 6'h3F, 24'hAABBCC, 6'h00, 24'h0,      64, 0);

    foreach (tv[i]) begin
      logic [71:0] bs;
      if (tv[i].rst) do_reset();
      wr_a.delete();
      wr_d.delete();
      bs = tv[i].bytes;
      open_txn();
      for (int k = 0; k < tv[i].n; k++) send_byte(bs[71 - 8 * k -: 8]);
      close_txn();
      chk($sformatf("v%0d_nwr", i), wr_a.size(), tv[i].nwr);
      for (int j = 0; j < tv[i].nwr; j++) begin
        if (j < wr_a.size()) begin
          chk($sformatf("v%0d_wa%0d", i, j), {26'd0, wr_a[j]}, {26'd0, tv[i].wa[j]});
          chk($sformatf("v%0d_wd%0d", i, j), {8'd0, wr_d[j]}, {8'd0, tv[i].wd[j]});
        end
      end
      chk($sformatf("v%0d_cnt", i), {25'd0, pix_count}, {25'd0, tv[i].cnt});
      chk($sformatf("v%0d_ovf", i), {31'd0, ovf_flag}, {31'd0, tv[i].ovf});
    end
    chk("tbl_no_start", start_cnt, 0);

    // B byte lands in the same cycle the synchronized chip select falls.
    wr_a.delete();
    wr_d.delete();
    open_txn();
    send_byte(8'h01);
    send_byte(8'h08);
    send_byte(8'hAA);
    send_byte(8'hBB);
    ssel_n = 1'b1;
    step(4);
    send_byte(8'hCC);
    step(8);
    chk("coinc_nwr", wr_a.size(), 1);
    if (wr_a.size() > 0) begin
      chk("coinc_wa", {26'd0, wr_a[0]}, 32'h08);
      chk("coinc_wd", {8'd0, wr_d[0]}, 32'hAABBCC);
    end

    // Show with serializer idle: one start.
    start_cnt = 0;
    open_txn();
    send_byte(8'h02);
    close_txn();
    chk("show_idle", start_cnt, 1);

    // Two shows while busy coalesce into one start after busy falls.
    start_cnt = 0;
    show_busy = 1'b1;
    open_txn(); send_byte(8'h02); close_txn();
    open_txn(); send_byte(8'h02); close_txn();
    chk("show_held", start_cnt, 0);
    show_busy = 1'b0;
    step(3);
    show_busy = 1'b1;  // serializer picks up the frame
    step(10);
    show_busy = 1'b0;
    step(10);
    chk("show_coalesce", start_cnt, 1);

    // Reset mid-PIX phase 1 with non-reset state present.
    open_txn(); send_byte(8'h03); send_byte(8'h0A); close_txn();
    open_txn(); send_byte(8'h07); close_txn();
    wr_a.delete();
    wr_d.delete();
    open_txn();
    send_byte(8'h01);
    send_byte(8'h04);
    send_byte(8'hAA);
    reset = 1'b1;
    step(2);
    chk("mrst_we", {31'd0, pix_we}, 32'd0);
    chk("mrst_addr", {26'd0, pix_addr}, 32'd0);
    chk("mrst_wdata", {8'd0, pix_wdata}, 32'd0);
    chk("mrst_count", {25'd0, pix_count}, 32'd64);
    chk("mrst_start", {31'd0, show_start}, 32'd0);
    chk("mrst_ovf", {31'd0, ovf_flag}, 32'd0);
    reset  = 1'b0;
    ssel_n = 1'b1;
    step(8);
    chk("mrst_nwr0", wr_a.size(), 0);
    open_txn();
    send_byte(8'h01); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    close_txn();
    chk("mrst_nwr1", wr_a.size(), 1);
    if (wr_a.size() > 0) begin
      chk("mrst_wa", {26'd0, wr_a[0]}, 32'h04);
      chk("mrst_wd", {8'd0, wr_d[0]}, 32'h112233);
    end
    chk("mrst_ovf_after", {31'd0, ovf_flag}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
